// File: rtl/freq_selector_pkg.sv
// Shared constants and helpers for the multi-lane frequency selector.
package freq_selector_pkg;

    // Register word indices, i.e. byte offset >> 2.
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_LEN    = 3'd1;
    localparam logic [2:0] REG_WPTR   = 3'd2;
    localparam logic [2:0] REG_WDATA  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_LANES  = 3'd5;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic [31:0] mergeBytes(input logic [31:0] oldVal,
                                               input logic [31:0] newVal,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = strb[b] ? newVal[b*8 +: 8] : oldVal[b*8 +: 8];
        end
        return merged;
    endfunction

    // LEN is never 0 and never exceeds the table depth.
    function automatic logic [31:0] clampLen(input logic [31:0] value,
                                             input int unsigned depthLog2);
        logic [31:0] depth;
        depth = 32'd1 << depthLog2;
        if (value == 32'd0) begin
            return 32'd1;
        end
        if (value > depth) begin
            return depth;
        end
        return value;
    endfunction

endpackage

// File: rtl/freq_selector_lane.sv
// One readout lane: walks the active table region and registers the emitted word.
module freq_selector_lane
    import freq_selector_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int FREQ_WIDTH = 24
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  rd_en_i,
    input  logic [DEPTH_LOG2:0]   len_i,
    input  logic [FREQ_WIDTH-1:0] entry_i,
    output logic [DEPTH_LOG2-1:0] ptr_o,
    output logic [FREQ_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    output logic                  wrap_o,
    output logic                  wrap_event_o
);

    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [FREQ_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  wrap_q, wrap_d;
    logic                  fire;
    logic                  atLast;

    assign fire = en_i & rd_en_i & ~clr_i;
    // ">=" so a LEN shrunk below the pointer still wraps on the next read.
    assign atLast = ({1'b0, ptr_q} >= (len_i - (DEPTH_LOG2 + 1)'(1)));
    assign wrap_event_o = fire & atLast;

    always_comb begin
        ptr_d   = ptr_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (clr_i) begin
            ptr_d = '0;
        end else if (fire) begin
            dout_d  = entry_i;
            valid_d = 1'b1;
            wrap_d  = atLast;
            ptr_d   = atLast ? '0 : ptr_q + DEPTH_LOG2'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign ptr_o        = ptr_q;
    assign dout_o       = dout_q;
    assign dout_valid_o = valid_q;
    assign wrap_o       = wrap_q;

endmodule

// File: rtl/freq_selector_multi.sv
// AXI4-Lite programmed frequency table feeding NUM_LANES independent readout lanes.
module freq_selector_multi
    import freq_selector_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter int NUM_LANES            = 4,
    parameter int DEPTH_LOG2           = 8,
    parameter int FREQ_WIDTH           = 24
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                          s00_axi_awprot,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S00_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                          s00_axi_arprot,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready,
    input  logic [NUM_LANES-1:0]                rd_en,
    output logic [NUM_LANES*FREQ_WIDTH-1:0]     dout,
    output logic [NUM_LANES-1:0]                dout_valid,
    output logic [NUM_LANES-1:0]                wrap,
    output logic [31:0]                         dout_mon
);

    localparam int IDX_W = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LEN_W = DEPTH_LOG2 + 1;

    logic                  awReady_q, awReady_d;
    logic                  bValid_q, bValid_d;
    logic                  arReady_q, arReady_d;
    logic                  rValid_q, rValid_d;
    logic [31:0]           rData_q, rData_d;
    logic                  enable_q, enable_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
    logic [NUM_LANES-1:0]  status_q, status_d;
    logic [31:0]           doutMon_q, doutMon_d;
    logic [FREQ_WIDTH-1:0] table_q [DEPTH];

    logic                  wrFire, rdFire, clrPulse, tableWrite;
    logic [IDX_W-1:0]      wrIdx, rdIdx;
    logic [31:0]           rdMux;
    logic [7:0]            statusByte;
    logic [NUM_LANES-1:0]  wrapEvent;
    logic [DEPTH_LOG2-1:0] lanePtr  [NUM_LANES];
    logic [FREQ_WIDTH-1:0] laneDout [NUM_LANES];
    logic                  unusedBits;

    assign wrIdx      = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign rdIdx      = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign wrFire     = awReady_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rdFire     = arReady_q & s00_axi_arvalid;
    assign clrPulse   = wrFire & (wrIdx == IDX_W'(REG_CTRL)) & s00_axi_wstrb[0]
                      & s00_axi_wdata[CTRL_CLR_BIT];
    assign tableWrite = s00_axi_aresetn & wrFire & (wrIdx == IDX_W'(REG_WDATA));
    assign statusByte = 8'(status_q);
    assign unusedBits = ^{s00_axi_awprot, s00_axi_arprot,
                          s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    always_comb begin
        rdMux = '0;
        case (rdIdx)
            IDX_W'(REG_CTRL):   rdMux = {31'd0, enable_q};
            IDX_W'(REG_LEN):    rdMux = 32'(len_q);
            IDX_W'(REG_WPTR):   rdMux = 32'(wrPtr_q);
            IDX_W'(REG_WDATA):  rdMux = 32'(table_q[wrPtr_q]);
            IDX_W'(REG_STATUS): rdMux = {24'd0, statusByte};
            IDX_W'(REG_LANES):  rdMux = {16'd0, 8'(DEPTH_LOG2), 8'(NUM_LANES)};
            default:            rdMux = '0;
        endcase
    end

    // Ready strobes are one-cycle pulses and cannot re-arm while a response is pending.
    always_comb begin
        awReady_d = ~awReady_q & s00_axi_awvalid & s00_axi_wvalid & ~bValid_q;
        arReady_d = ~arReady_q & s00_axi_arvalid & ~rValid_q;
        bValid_d  = bValid_q;
        rValid_d  = rValid_q;
        rData_d   = rData_q;
        if (bValid_q && s00_axi_bready) begin
            bValid_d = 1'b0;
        end
        if (wrFire) begin
            bValid_d = 1'b1;
        end
        if (rValid_q && s00_axi_rready) begin
            rValid_d = 1'b0;
        end
        if (rdFire) begin
            rValid_d = 1'b1;
            rData_d  = rdMux;
        end

        enable_d = enable_q;
        len_d    = len_q;
        wrPtr_d  = wrPtr_q;
        if (wrFire) begin
            case (wrIdx)
                IDX_W'(REG_CTRL): begin
                    if (s00_axi_wstrb[0]) begin
                        enable_d = s00_axi_wdata[CTRL_EN_BIT];
                    end
                end
                IDX_W'(REG_LEN):
                    len_d = LEN_W'(clampLen(mergeBytes(32'(len_q), s00_axi_wdata,
                                                       s00_axi_wstrb), DEPTH_LOG2));
                IDX_W'(REG_WPTR):
                    wrPtr_d = DEPTH_LOG2'(mergeBytes(32'(wrPtr_q), s00_axi_wdata,
                                                     s00_axi_wstrb));
                IDX_W'(REG_WDATA):
                    wrPtr_d = wrPtr_q + DEPTH_LOG2'(1);
                default: ;
            endcase
        end

        status_d  = clrPulse ? '0 : (status_q | wrapEvent);
        doutMon_d = 32'(laneDout[0]);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awReady_q <= 1'b0;
            bValid_q  <= 1'b0;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
            enable_q  <= 1'b0;
            len_q     <= LEN_W'(1);
            wrPtr_q   <= '0;
            status_q  <= '0;
            doutMon_q <= '0;
        end else begin
            awReady_q <= awReady_d;
            bValid_q  <= bValid_d;
            arReady_q <= arReady_d;
            rValid_q  <= rValid_d;
            rData_q   <= rData_d;
            enable_q  <= enable_d;
            len_q     <= len_d;
            wrPtr_q   <= wrPtr_d;
            status_q  <= status_d;
            doutMon_q <= doutMon_d;
        end
    end

    // Table contents survive reset; lanes read the pre-write value on a same-cycle write.
    always_ff @(posedge s00_axi_aclk) begin
        if (tableWrite) begin
            table_q[wrPtr_q] <= s00_axi_wdata[FREQ_WIDTH-1:0];
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
        freq_selector_lane #(
            .DEPTH_LOG2(DEPTH_LOG2),
            .FREQ_WIDTH(FREQ_WIDTH)
        ) uLane (
            .clk_i        (s00_axi_aclk),
            .rst_ni       (s00_axi_aresetn),
            .en_i         (enable_q),
            .clr_i        (clrPulse),
            .rd_en_i      (rd_en[k]),
            .len_i        (len_q),
            .entry_i      (table_q[lanePtr[k]]),
            .ptr_o        (lanePtr[k]),
            .dout_o       (laneDout[k]),
            .dout_valid_o (dout_valid[k]),
            .wrap_o       (wrap[k]),
            .wrap_event_o (wrapEvent[k])
        );
        assign dout[k*FREQ_WIDTH +: FREQ_WIDTH] = laneDout[k];
    end

    assign s00_axi_awready = awReady_q;
    assign s00_axi_wready  = awReady_q;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_bvalid  = bValid_q;
    assign s00_axi_arready = arReady_q;
    assign s00_axi_rdata   = rData_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign s00_axi_rvalid  = rValid_q;
    assign dout_mon        = doutMon_q;

endmodule

// File: tb/tb_freq_selector_multi.sv
// Scoreboard bench: stimulus pushes hand-computed lane words and read data; a monitor pops and compares.
module tb_freq_selector_multi;

    typedef struct packed {
        logic [1:0]  lane;
        logic [23:0] data;
        logic        wrapFlag;
    } laneExp_t;

    logic        clk;
    logic        aresetn;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [3:0]  rd_en;
    logic [95:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  wrap;
    logic [31:0] dout_mon;

    laneExp_t    laneQ[$];
    logic [31:0] readQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;

    freq_selector_multi dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .rd_en           (rd_en),
        .dout            (dout),
        .dout_valid      (dout_valid),
        .wrap            (wrap),
        .dout_mon        (dout_mon)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives rd_en for one cycle and queues the word the addressed lane must emit.
    task automatic applyStimulus(input logic [3:0] mask, input int lane,
                                 input logic [23:0] data, input logic wrapFlag);
        laneQ.push_back('{lane: 2'(lane), data: data, wrapFlag: wrapFlag});
        rd_en = mask;
        @(posedge clk); #1;
        rd_en = '0;
    endtask

    task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] rdAtFire);
        int cycles;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!(awready && wready) && cycles < 20);
        checkOutput("awreadyWait", 32'(awready && wready), 32'd1);
        rd_en = rdAtFire;
        @(posedge clk); #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        rd_en   = '0;
        cycles  = 0;
        while (!bvalid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("bvalidWait", 32'(bvalid), 32'd1);
        checkOutput("bresp", 32'(bresp), 32'd0);
        if (bready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic axiRead(input logic [4:0] addr, input logic [31:0] expected);
        int cycles;
        readQ.push_back(expected);
        araddr  = addr;
        arvalid = 1'b1;
        cycles  = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!arready && cycles < 20);
        checkOutput("arreadyWait", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        cycles  = 0;
        while (!rvalid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("rvalidWait", 32'(rvalid), 32'd1);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (aresetn) begin
            for (int k = 0; k < 4; k++) begin
                if (dout_valid[k]) begin
                    if (laneQ.size() == 0) begin
                        checkOutput($sformatf("unexpectedValid%0d", k), 32'(dout_valid[k]), 32'd0);
                    end else begin
                        laneExp_t e;
                        e = laneQ.pop_front();
                        checkOutput("laneIndex", 32'(k), 32'(e.lane));
                        checkOutput($sformatf("laneData%0d", k), 32'(dout[k*24 +: 24]), 32'(e.data));
                        checkOutput($sformatf("laneWrap%0d", k), 32'(wrap[k]), 32'(e.wrapFlag));
                    end
                end else if (wrap[k]) begin
                    checkOutput($sformatf("wrapWithoutValid%0d", k), 32'(wrap[k]), 32'd0);
                end
            end
            if (rvalid && rready) begin
                if (readQ.size() == 0) begin
                    checkOutput("unexpectedRvalid", 32'(rvalid), 32'd0);
                end else begin
                    checkOutput("rdata", rdata, readQ.pop_front());
                    checkOutput("rresp", 32'(rresp), 32'd0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b1;
        rd_en = '0;
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        @(negedge clk);
        checkOutput("resetDoutValid", 32'(dout_valid), 32'd0);
        checkOutput("resetDout", 32'(dout != '0), 32'd0);
        checkOutput("resetWrap", 32'(wrap), 32'd0);
        checkOutput("resetDoutMon", dout_mon, 32'd0);
        checkOutput("resetBvalid", 32'(bvalid), 32'd0);
        checkOutput("resetRvalid", 32'(rvalid), 32'd0);
        @(posedge clk); #1;

        axiRead(5'h14, 32'h0000_0804);
        axiRead(5'h04, 32'd1);

        // Program 100,200,300 with LEN=3 and enable.
        axiWrite(5'h08, 32'd0, 4'hF, 4'h0);
        axiWrite(5'h0C, 32'd100, 4'hF, 4'h0);
        axiWrite(5'h0C, 32'd200, 4'hF, 4'h0);
        axiWrite(5'h0C, 32'd300, 4'hF, 4'h0);
        axiWrite(5'h04, 32'd3, 4'hF, 4'h0);
        axiWrite(5'h00, 32'd1, 4'hF, 4'h0);
        axiRead(5'h08, 32'd3);

        applyStimulus(4'b0001, 0, 24'd100, 1'b0);
        applyStimulus(4'b0001, 0, 24'd200, 1'b0);
        applyStimulus(4'b0001, 0, 24'd300, 1'b1);
        applyStimulus(4'b0001, 0, 24'd100, 1'b0);
        axiRead(5'h10, 32'h1);
        @(negedge clk);
        checkOutput("doutMon", dout_mon, 32'd100);
        @(posedge clk); #1;

        // Lanes 2 and 0 on alternate cycles keep separate pointers.
        applyStimulus(4'b0100, 2, 24'd100, 1'b0);
        applyStimulus(4'b0001, 0, 24'd200, 1'b0);
        applyStimulus(4'b0100, 2, 24'd200, 1'b0);
        applyStimulus(4'b0001, 0, 24'd300, 1'b1);
        axiRead(5'h10, 32'h1);
        applyStimulus(4'b0100, 2, 24'd300, 1'b1);
        axiRead(5'h10, 32'h5);

        // CLR together with rd_en[1]: no output, pointers and STATUS cleared.
        axiWrite(5'h00, 32'h3, 4'h1, 4'b0010);
        applyStimulus(4'b0010, 1, 24'd100, 1'b0);
        axiRead(5'h10, 32'h0);

        // Table write colliding with a lane read of the same entry returns the old word.
        axiWrite(5'h08, 32'd0, 4'hF, 4'h0);
        laneQ.push_back('{lane: 2'd0, data: 24'd100, wrapFlag: 1'b0});
        axiWrite(5'h0C, 32'd555, 4'hF, 4'b0001);
        applyStimulus(4'b0001, 0, 24'd200, 1'b0);
        applyStimulus(4'b0001, 0, 24'd300, 1'b1);
        applyStimulus(4'b0001, 0, 24'd555, 1'b0);

        // Shrinking LEN below a lane pointer wraps on the next read.
        applyStimulus(4'b1000, 3, 24'd555, 1'b0);
        applyStimulus(4'b1000, 3, 24'd200, 1'b0);
        axiWrite(5'h04, 32'd1, 4'hF, 4'h0);
        applyStimulus(4'b1000, 3, 24'd300, 1'b1);
        applyStimulus(4'b1000, 3, 24'd555, 1'b1);
        axiRead(5'h10, 32'h9);

        // EN=0: rd_en ignored and dout holds.
        axiWrite(5'h00, 32'd0, 4'h1, 4'h0);
        rd_en = 4'b0001;
        @(posedge clk); #1;
        rd_en = '0;
        @(negedge clk);
        checkOutput("disabledValid", 32'(dout_valid), 32'd0);
        checkOutput("disabledHold", 32'(dout[23:0]), 32'd555);
        @(posedge clk); #1;

        axiWrite(5'h04, 32'd0, 4'hF, 4'h0);
        axiRead(5'h04, 32'd1);
        axiWrite(5'h04, 32'h1000, 4'hF, 4'h0);
        axiRead(5'h04, 32'd256);
        axiWrite(5'h08, 32'h12, 4'hF, 4'h0);
        axiWrite(5'h08, 32'h3400, 4'h2, 4'h0);
        axiRead(5'h08, 32'h12);
        axiWrite(5'h08, 32'd2, 4'hF, 4'h0);
        axiRead(5'h0C, 32'd300);
        axiRead(5'h00, 32'd0);
        axiRead(5'h18, 32'd0);
        axiWrite(5'h1C, 32'hFFFF, 4'hF, 4'h0);
        axiRead(5'h04, 32'd256);

        // Reset while a write response is stalled.
        axiWrite(5'h04, 32'd5, 4'hF, 4'h0);
        bready = 1'b0;
        axiWrite(5'h00, 32'd1, 4'hF, 4'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("bvalidHeld", 32'(bvalid), 32'd1);
        aresetn = 1'b0;
        @(posedge clk); #1;
        aresetn = 1'b1;
        bready  = 1'b1;
        @(negedge clk);
        checkOutput("midResetBvalid", 32'(bvalid), 32'd0);
        checkOutput("midResetDout", 32'(dout != '0), 32'd0);
        checkOutput("midResetValid", 32'(dout_valid), 32'd0);
        checkOutput("midResetDoutMon", dout_mon, 32'd0);
        @(posedge clk); #1;
        axiRead(5'h00, 32'd0);
        axiRead(5'h04, 32'd1);
        axiRead(5'h08, 32'd0);
        axiRead(5'h10, 32'd0);

        repeat (4) @(posedge clk);
        checkOutput("laneQueueDrained", 32'(laneQ.size()), 32'd0);
        checkOutput("readQueueDrained", 32'(readQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
